// File: rtl/rom_bus_arbiter.sv
// Two-master round-robin arbiter sharing the single-port instruction ROM.
// Optional bus-timeout abort is enabled by defining ROM_ARB_TIMEOUT_EN.
module rom_bus_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_n,
  output logic              m0_grnt_n,
  input  logic              m0_cs_n,
  input  logic              m0_as_n,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rdy_n,
  output logic              m0_err,
  input  logic              m1_req_n,
  output logic              m1_grnt_n,
  input  logic              m1_cs_n,
  input  logic              m1_as_n,
  input  logic [ADDR_W-1:0] m1_addr,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rdy_n,
  output logic              m1_err,
  output logic              rom_cs_n,
  output logic              rom_as_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_rd_data,
  input  logic              rom_rdy_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  state_e prev_state_q;
  logic   last_owner_q, last_owner_d;
  logic   req0_s, req1_s;
  logic   tmo0_s, tmo1_s;

`ifdef ROM_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [1:0]       lock_q, lock_d;
  logic [1:0]       err_q, err_d;
  logic             owner_as_s;
  logic             tmo_hit_s;

  // A master that timed out stays locked out until it drops its request.
  assign req0_s = ~m0_req_n & ~lock_q[0];
  assign req1_s = ~m1_req_n & ~lock_q[1];

  assign owner_as_s = ((state_q == OWN0) && !m0_as_n) || ((state_q == OWN1) && !m1_as_n);
  assign tmo_hit_s  = owner_as_s && rom_rdy_n && (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1));
  assign tmo0_s     = tmo_hit_s && (state_q == OWN0);
  assign tmo1_s     = tmo_hit_s && (state_q == OWN1);

  // Timeout counter, error pulses and lockout flags next-state
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = {tmo1_s, tmo0_s};
    lock_d[0] = tmo0_s | (lock_q[0] & ~m0_req_n);
    lock_d[1] = tmo1_s | (lock_q[1] & ~m1_req_n);
    if ((state_d != state_q) || !rom_rdy_n) begin
      tmo_cnt_d = {TMO_W{1'b0}};
    end else if (owner_as_s) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Timeout state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      tmo_cnt_q <= {TMO_W{1'b0}};
      lock_q    <= 2'b00;
      err_q     <= 2'b00;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      lock_q    <= lock_d;
      err_q     <= err_d;
    end
  end

  assign m0_err = err_q[0];
  assign m1_err = err_q[1];
`else
  assign req0_s = ~m0_req_n;
  assign req1_s = ~m1_req_n;
  assign tmo0_s = 1'b0;
  assign tmo1_s = 1'b0;
  assign m0_err = 1'b0;
  assign m1_err = 1'b0;
`endif

  // Ownership FSM next-state and round-robin pointer
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    case (state_q)
      IDLE: begin
        if (req0_s && req1_s) begin
          state_d = last_owner_q ? OWN0 : OWN1;
        end else if (req0_s) begin
          state_d = OWN0;
        end else if (req1_s) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (m0_req_n || tmo0_s) begin
          state_d = req1_s ? OWN1 : IDLE;
        end else begin
          state_d = OWN0;
        end
      end
      OWN1: begin
        if (m1_req_n || tmo1_s) begin
          state_d = req0_s ? OWN0 : IDLE;
        end else begin
          state_d = OWN1;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_d == OWN0) && (state_q != OWN0)) begin
      last_owner_d = 1'b0;
    end else if ((state_d == OWN1) && (state_q != OWN1)) begin
      last_owner_d = 1'b1;
    end else begin
      last_owner_d = last_owner_q;
    end
  end

  // FSM state registers; prev_state_q qualifies ROM ready to the current tenure
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_state_q <= IDLE;
      last_owner_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      prev_state_q <= state_q;
      last_owner_q <= last_owner_d;
    end
  end

  assign m0_grnt_n = (state_q != OWN0);
  assign m1_grnt_n = (state_q != OWN1);

  // ROM request mux and read-return demux, steered by the registered owner
  always_comb begin
    rom_cs_n   = 1'b1;
    rom_as_n   = 1'b1;
    rom_addr   = {ADDR_W{1'b0}};
    m0_rd_data = {DATA_W{1'b0}};
    m1_rd_data = {DATA_W{1'b0}};
    m0_rdy_n   = 1'b1;
    m1_rdy_n   = 1'b1;
    case (state_q)
      OWN0: begin
        rom_cs_n   = m0_cs_n;
        rom_as_n   = m0_as_n;
        rom_addr   = m0_addr;
        m0_rd_data = rom_rd_data;
        if (prev_state_q == OWN0) begin
          m0_rdy_n = rom_rdy_n;
        end else begin
          m0_rdy_n = 1'b1;
        end
      end
      OWN1: begin
        rom_cs_n   = m1_cs_n;
        rom_as_n   = m1_as_n;
        rom_addr   = m1_addr;
        m1_rd_data = rom_rd_data;
        if (prev_state_q == OWN1) begin
          m1_rdy_n = rom_rdy_n;
        end else begin
          m1_rdy_n = 1'b1;
        end
      end
      default: begin
        rom_cs_n = 1'b1;
        rom_as_n = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_bus_arbiter.sv
// Directed self-checking bench for rom_bus_arbiter with a one-cycle-latency ROM model.
module tb_rom_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req_n, m0_grnt_n, m0_cs_n, m0_as_n, m0_rdy_n, m0_err;
  logic [10:0] m0_addr;
  logic [31:0] m0_rd_data;
  logic        m1_req_n, m1_grnt_n, m1_cs_n, m1_as_n, m1_rdy_n, m1_err;
  logic [10:0] m1_addr;
  logic [31:0] m1_rd_data;
  logic        rom_cs_n, rom_as_n;
  logic [10:0] rom_addr;
  bit   [31:0] rom_rd_data;
  bit          rom_rdy_n;
  bit          rom_stuck;

  int checks;
  int errors;

  rom_bus_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .m0_req_n   (m0_req_n),
    .m0_grnt_n  (m0_grnt_n),
    .m0_cs_n    (m0_cs_n),
    .m0_as_n    (m0_as_n),
    .m0_addr    (m0_addr),
    .m0_rd_data (m0_rd_data),
    .m0_rdy_n   (m0_rdy_n),
    .m0_err     (m0_err),
    .m1_req_n   (m1_req_n),
    .m1_grnt_n  (m1_grnt_n),
    .m1_cs_n    (m1_cs_n),
    .m1_as_n    (m1_as_n),
    .m1_addr    (m1_addr),
    .m1_rd_data (m1_rd_data),
    .m1_rdy_n   (m1_rdy_n),
    .m1_err     (m1_err),
    .rom_cs_n   (rom_cs_n),
    .rom_as_n   (rom_as_n),
    .rom_addr   (rom_addr),
    .rom_rd_data(rom_rd_data),
    .rom_rdy_n  (rom_rdy_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ROM: word = 0xA5000000 | addr, ready one cycle after a strobe
  always @(posedge clk) begin
    rom_rdy_n   <= rom_stuck | rom_cs_n | rom_as_n;
    rom_rd_data <= 32'hA500_0000 | {21'd0, rom_addr};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int m, input logic req_n, input logic cs_n, input logic as_n,
                     input logic [10:0] addr);
    if (m == 0) begin
      m0_req_n = req_n; m0_cs_n = cs_n; m0_as_n = as_n; m0_addr = addr;
    end else begin
      m1_req_n = req_n; m1_cs_n = cs_n; m1_as_n = as_n; m1_addr = addr;
    end
  endtask

  initial begin
    int own;
    logic [10:0] a;
    checks = 0;
    errors = 0;
    rom_stuck = 1'b0;
    reset = 1'b1;
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    drv(1, 1'b0, 1'b1, 1'b1, 11'h000);

    // 1: reset with both requests low
    tick(); tick(); tick();
    check("rst_m0_grnt", m0_grnt_n, 1'b1);
    check("rst_m1_grnt", m1_grnt_n, 1'b1);
    check("rst_rom_cs", rom_cs_n, 1'b1);
    check("rst_rom_as", rom_as_n, 1'b1);
    check("rst_rom_addr", rom_addr, 11'h000);
    check("rst_m0_rdy", m0_rdy_n, 1'b1);
    check("rst_m1_rdy", m1_rdy_n, 1'b1);
    check("rst_m0_data", m0_rd_data, 32'h0);
    check("rst_err", {m1_err, m0_err}, 2'b00);
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);
    drv(1, 1'b1, 1'b1, 1'b1, 11'h000);
    reset = 1'b0;
    tick();
    check("idle_grnt", {m1_grnt_n, m0_grnt_n}, 2'b11);

    // 2: single m0 read
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    check("t2_m0_grnt", m0_grnt_n, 1'b0);
    check("t2_m1_grnt", m1_grnt_n, 1'b1);
    drv(0, 1'b0, 1'b0, 1'b0, 11'h010);
    #1;
    check("t2_rom_addr", rom_addr, 11'h010);
    check("t2_rom_cs", {rom_cs_n, rom_as_n}, 2'b00);
    check("t2_m0_rdy_early", m0_rdy_n, 1'b1);
    tick();
    check("t2_m0_rdy", m0_rdy_n, 1'b0);
    check("t2_m0_data", m0_rd_data, 32'hA500_0010);
    check("t2_m1_rdy", m1_rdy_n, 1'b1);
    check("t2_m1_data", m1_rd_data, 32'h0);
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
    check("t2_release_grnt", m0_grnt_n, 1'b1);
    check("t2_release_cs", rom_cs_n, 1'b1);
    check("t2_release_rdy", m0_rdy_n, 1'b1);

    // 3: both requesting after reset alternate 0,1,0,1 with 2-word bursts
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    drv(1, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    for (int k = 0; k < 4; k++) begin
      own = k % 2;
      a = 11'h100 + 11'(k * 16);
      check("t3_owner_grnt", (own == 0) ? m0_grnt_n : m1_grnt_n, 1'b0);
      check("t3_other_grnt", (own == 0) ? m1_grnt_n : m0_grnt_n, 1'b1);
      drv(own, 1'b0, 1'b0, 1'b0, a);
      tick();
      drv(own, 1'b0, 1'b0, 1'b0, a + 11'h001);
      check("t3_rdy0", (own == 0) ? m0_rdy_n : m1_rdy_n, 1'b0);
      check("t3_data0", (own == 0) ? m0_rd_data : m1_rd_data, 32'hA500_0000 | {21'd0, a});
      tick();
      check("t3_rdy1", (own == 0) ? m0_rdy_n : m1_rdy_n, 1'b0);
      check("t3_data1", (own == 0) ? m0_rd_data : m1_rd_data,
            32'hA500_0000 | {21'd0, a + 11'h001});
      check("t3_other_rdy", (own == 0) ? m1_rdy_n : m0_rdy_n, 1'b1);
      drv(own, 1'b1, 1'b1, 1'b1, 11'h000);
      tick();
      drv(own, 1'b0, 1'b1, 1'b1, 11'h000);
    end
    check("t3_back_to_m0", m0_grnt_n, 1'b0);
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);
    drv(1, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
    check("t3_idle", {m1_grnt_n, m0_grnt_n}, 2'b11);

    // 4: m1 owns while m0 strobes without a grant
    drv(1, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    check("t4_m1_grnt", m1_grnt_n, 1'b0);
    drv(1, 1'b0, 1'b0, 1'b0, 11'h020);
    drv(0, 1'b1, 1'b0, 1'b0, 11'h7FF);
    #1;
    check("t4_rom_addr", rom_addr, 11'h020);
    check("t4_m0_rdy_a", m0_rdy_n, 1'b1);
    tick();
    check("t4_m1_rdy", m1_rdy_n, 1'b0);
    check("t4_m1_data", m1_rd_data, 32'hA500_0020);
    check("t4_m0_rdy_b", m0_rdy_n, 1'b1);
    check("t4_m0_data", m0_rd_data, 32'h0);
    drv(1, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
    check("t4_idle_cs", rom_cs_n, 1'b1);
    check("t4_idle_addr", rom_addr, 11'h000);
    check("t4_m0_rdy_c", m0_rdy_n, 1'b1);
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);

    // 5: reset mid-burst; first tie after reset goes to m0
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    drv(0, 1'b0, 1'b0, 1'b0, 11'h030);
    tick();
    check("t5_rdy_before", m0_rdy_n, 1'b0);
    drv(0, 1'b0, 1'b0, 1'b0, 11'h031);
    reset = 1'b1;
    tick();
    check("t5_rst_grnt", m0_grnt_n, 1'b1);
    check("t5_rst_as", rom_as_n, 1'b1);
    check("t5_rst_cs", rom_cs_n, 1'b1);
    check("t5_rst_rdy_drop", m0_rdy_n, 1'b1);
    reset = 1'b0;
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    drv(1, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    check("t5_tie_m0", m0_grnt_n, 1'b0);
    check("t5_tie_m1", m1_grnt_n, 1'b1);
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);
    drv(1, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
    check("t5_idle", {m1_grnt_n, m0_grnt_n}, 2'b11);

`ifdef ROM_ARB_TIMEOUT_EN
    // 6: ROM never ready -> m0 aborted after 16 cycles, m1 gets the bus
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    check("t6_m0_grnt", m0_grnt_n, 1'b0);
    rom_stuck = 1'b1;
    drv(0, 1'b0, 1'b0, 1'b0, 11'h040);
    drv(1, 1'b0, 1'b1, 1'b1, 11'h000);
    for (int i = 0; i < 15; i++) tick();
    check("t6_err_early", m0_err, 1'b0);
    check("t6_grnt_early", m0_grnt_n, 1'b0);
    tick();
    check("t6_err_pulse", m0_err, 1'b1);
    check("t6_m1_err", m1_err, 1'b0);
    check("t6_m1_grnt", m1_grnt_n, 1'b0);
    check("t6_m0_drop", m0_grnt_n, 1'b1);
    drv(1, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
    check("t6_err_one", m0_err, 1'b0);
    check("t6_locked_a", {m1_grnt_n, m0_grnt_n}, 2'b11);
    tick();
    check("t6_locked_b", m0_grnt_n, 1'b1);
    rom_stuck = 1'b0;
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
    drv(0, 1'b0, 1'b1, 1'b1, 11'h000);
    tick();
    check("t6_unlocked", m0_grnt_n, 1'b0);
    drv(0, 1'b1, 1'b1, 1'b1, 11'h000);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
